mem_bus_arbiter: RTL and testbench

- Shares one external memory bus (single outstanding transaction, ack-terminated) between the instruction-fetch port and the data-access (MEM stage) port of the 5-stage core.
- Data requests win over fetch requests.
- Produces a stall request to ctrl while any requester waits.
- Handles pipeline flush on fetch and bus timeout.

---
 rtl/mem_bus_arbiter.sv | 112 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one ack-terminated memory bus between fetch and data ports
// Data requests have priority; a flushed fetch still completes on the bus but is not acknowledged.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_drop;
  logic        w_timeout;
  logic [DATA_W-1:0] w_rdata;

  // The busy cycle that sees the counter at TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th one.
  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_rdata   = bus_ack_i ? bus_rdata_i : {DATA_W{1'b0}};

  assign stallreq_o = (if_req_i & ~if_ack_o & ~flush_i) | (mem_req_i & ~mem_ack_o);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_drop      <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'b0000;
      bus_addr_o  <= {ADDR_W{1'b0}};
      bus_wdata_o <= {DATA_W{1'b0}};
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_rdata_o  <= {DATA_W{1'b0}};
      mem_rdata_o <= {DATA_W{1'b0}};
      bus_err_o   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 8'd0;
          if (mem_req_i) begin
            r_state     <= MEM_BUSY;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_sel_o   <= mem_sel_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
          end else if (if_req_i && !flush_i) begin
            r_state    <= IF_BUSY;
            bus_req_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= 4'b1111;
            bus_addr_o <= if_addr_i;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (r_state == IF_BUSY && flush_i) r_drop <= 1'b1;
          if (bus_ack_i || w_timeout) begin
            r_state   <= DONE;
            bus_req_o <= 1'b0;
            bus_err_o <= ~bus_ack_i;
            if (r_state == MEM_BUSY) begin
              mem_ack_o   <= 1'b1;
              mem_rdata_o <= w_rdata;
            end else if (!(r_drop || flush_i)) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_drop      <= 1'b0;
          if_ack_o    <= 1'b0;
          mem_ack_o   <= 1'b0;
          if_rdata_o  <= {DATA_W{1'b0}};
          mem_rdata_o <= {DATA_W{1'b0}};
          bus_err_o   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
// Each transaction's cycle-by-cycle expectations are derived from its wait count and flush point.
module tb_mem_bus_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, flush_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ack_o, mem_ack_o, bus_req_o, bus_we_o, bus_err_o, stallreq_o;
  logic [3:0]  bus_sel_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .flush_i(flush_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_start;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_sample;
    @(negedge clk);
  endtask

  task automatic idle_cycle;
    if_req_i = 0; mem_req_i = 0; bus_ack_i = 0;
    flush_i = 1'($urandom_range(0, 1));
    bus_rdata_i = $urandom;
    cyc_sample;
    chk("idle.bus_req", 32'(bus_req_o), 0);
    chk("idle.acks", {30'd0, if_ack_o, mem_ack_o}, 0);
    chk("idle.stall", 32'(stallreq_o), 0);
    cyc_start;
  endtask

  // One transaction granted in the first cycle; the bus acks after `waits` busy cycles
  // without ack, or never if waits >= T (timeout). flush_cyc < 0 means no flush.
  task automatic txn(input bit is_mem, input bit we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int waits, input int flush_cyc, input bit if_waiting);
    bit timed_out, dropped, fl, ireq, mreq, exp_if_ack, exp_mem_ack, exp_stall;
    int done;
    logic [31:0] exp_data;
    timed_out = (waits >= T);
    done      = timed_out ? 1 + T : 2 + waits;
    dropped   = !is_mem && flush_cyc >= 1 && flush_cyc < done;
    exp_data  = timed_out ? 32'd0 : rdata;
    for (int c = 0; c <= done; c++) begin
      fl    = (c == flush_cyc);
      mreq  = is_mem;
      ireq  = is_mem ? if_waiting : (dropped ? (c <= flush_cyc) : 1'b1);
      if_req_i    = ireq;
      if_addr_i   = (!is_mem && c == 0) ? addr : $urandom;
      mem_req_i   = mreq;
      mem_we_i    = (is_mem && c == 0) ? we : 1'($urandom_range(0, 1));
      mem_sel_i   = (is_mem && c == 0) ? sel : 4'($urandom_range(0, 15));
      mem_addr_i  = (is_mem && c == 0) ? addr : $urandom;
      mem_wdata_i = (is_mem && c == 0) ? wdata : $urandom;
      flush_i     = fl;
      bus_ack_i   = !timed_out && (c == 1 + waits);
      bus_rdata_i = bus_ack_i ? rdata : $urandom;
      exp_if_ack  = (c == done) && !is_mem && !dropped;
      exp_mem_ack = (c == done) && is_mem;
      exp_stall   = (ireq && !exp_if_ack && !fl) || (mreq && !exp_mem_ack);
      cyc_sample;
      chk($sformatf("c%0d.bus_req", c), 32'(bus_req_o), 32'(c >= 1 && c < done));
      if (c >= 1 && c < done) begin
        chk($sformatf("c%0d.bus_addr", c), bus_addr_o, addr);
        chk($sformatf("c%0d.bus_we", c), 32'(bus_we_o), is_mem ? 32'(we) : 0);
        chk($sformatf("c%0d.bus_sel", c), 32'(bus_sel_o), is_mem ? 32'(sel) : 32'hF);
        if (is_mem) chk($sformatf("c%0d.bus_wdata", c), bus_wdata_o, wdata);
      end
      chk($sformatf("c%0d.if_ack", c), 32'(if_ack_o), 32'(exp_if_ack));
      chk($sformatf("c%0d.mem_ack", c), 32'(mem_ack_o), 32'(exp_mem_ack));
      chk($sformatf("c%0d.if_rdata", c), if_rdata_o, exp_if_ack ? exp_data : 32'd0);
      chk($sformatf("c%0d.mem_rdata", c), mem_rdata_o, exp_mem_ack ? exp_data : 32'd0);
      chk($sformatf("c%0d.bus_err", c), 32'(bus_err_o), 32'(c == done && timed_out));
      chk($sformatf("c%0d.stall", c), 32'(stallreq_o), 32'(exp_stall));
      cyc_start;
    end
  endtask

  initial begin
    rst = 0;
    if_req_i = 0; mem_req_i = 0; mem_we_i = 0; flush_i = 0; bus_ack_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0; bus_rdata_i = 0;
    repeat (2) @(posedge clk);
    cyc_sample;
    chk("reset.bus", {bus_req_o, bus_we_o, bus_sel_o, bus_err_o}, 0);
    chk("reset.bus_addr", bus_addr_o, 0);
    chk("reset.bus_wdata", bus_wdata_o, 0);
    chk("reset.acks", {if_ack_o, mem_ack_o}, 0);
    chk("reset.rdata", if_rdata_o | mem_rdata_o, 0);
    cyc_start;
    rst = 1;
    idle_cycle;

    txn(0, 0, 4'h0, 32'h10, 0, 32'h34011100, 2, -1, 0);
    idle_cycle;
    txn(1, 1, 4'b0011, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1, 1);
    txn(0, 0, 4'h0, 32'h40, 0, 32'h13000013, 0, -1, 0);
    idle_cycle;
    txn(0, 0, 4'h0, 32'h80, 0, 32'hCAFEF00D, 3, 2, 0);
    idle_cycle;
    txn(0, 0, 4'h0, 32'h84, 0, 32'h11112222, 1, 2, 0);
    idle_cycle;
    txn(1, 0, 4'hF, 32'h180, 0, 32'h55AA55AA, 10, -1, 0);
    idle_cycle;

    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h300;
    cyc_sample;
    chk("rst_mid.stall", 32'(stallreq_o), 1);
    cyc_start;
    cyc_sample;
    chk("rst_mid.bus_req_before", 32'(bus_req_o), 1);
    #2 rst = 0;
    #1;
    chk("rst_mid.bus_req_async", 32'(bus_req_o), 0);
    chk("rst_mid.no_ack", {mem_ack_o, bus_err_o}, 0);
    cyc_start;
    mem_req_i = 0;
    rst = 1;
    cyc_sample;
    chk("rst_mid.after", {bus_req_o, mem_ack_o, if_ack_o}, 0);
    cyc_start;
    txn(0, 0, 4'h0, 32'h20, 0, 32'h00A00093, 1, -1, 0);

    txn(1, 0, 4'hF, 32'h200, 0, 32'h01020304, 1, -1, 0);
    txn(1, 0, 4'hF, 32'h204, 0, 32'h05060708, 0, -1, 0);
    idle_cycle;

    for (int i = 0; i < 60; i++) begin
      bit m;
      m = 1'($urandom_range(0, 1));
      txn(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 5)),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : -1,
          m && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) idle_cycle;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
